// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//   Four-to-one round-robin arbiter that drains four upstream packet FIFOs
//   into one shared downstream FIFO. Pops are issued to one granted source
//   at a time in bursts of at most BURST_LEN. The popped word is pushed
//   downstream two cycles after its pop. Downstream almost_full throttles
//   popping, and a downstream error is latched sticky.
//
//   Sources must raise almost_empty with two or fewer words left. in_empty
//   lags a pop by one cycle, so back-to-back pops are only safe above that
//   level.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high
//   in_empty[3:0]    source FIFO empty flags
//   in_almost_empty  source FIFO almost_empty flags
//   in_data          source read data, source i at [i*DATA_SIZE +: DATA_SIZE]
//   out_almost_full  downstream almost_full (must leave >= 2 free entries)
//   out_error        downstream fifo_error
//   pop[3:0]         one-hot registered read strobe to the sources
//   push             registered write strobe to the downstream FIFO
//   data_out         registered write data to the downstream FIFO
//   grant_id         currently granted source
//   busy             arbiter active or a word still in the pipeline
//   arb_error        sticky downstream error, cleared only by reset
//
// Optional feature
//   ARB_STRICT_P0_EN  when defined, source 0 is a strict-priority class.
//                     It is granted whenever non-empty, preempts other
//                     bursts, and its bursts leave the pointer unchanged.

module fifo_rr_arbiter #(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             in_empty,
    input  logic [3:0]             in_almost_empty,
    input  logic [4*DATA_SIZE-1:0] in_data,
    input  logic                   out_almost_full,
    input  logic                   out_error,
    output logic [3:0]             pop,
    output logic                   push,
    output logic [DATA_SIZE-1:0]   data_out,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   arb_error
);

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        PAUSE
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [1:0]           ptr;
    logic [1:0]           ptr_n;
    logic [1:0]           grant_n;
    logic [3:0]           burst_cnt;
    logic [3:0]           burst_cnt_n;
    logic                 gap;
    logic                 gap_n;
    logic [3:0]           pop_n;
    logic                 pend;
    logic [1:0]           pend_id;
    logic                 found;
    logic [1:0]           pick;
    logic                 p0_preempt;
    logic                 ptr_upd;
    logic [DATA_SIZE-1:0] sel_data;

`ifdef ARB_STRICT_P0_EN
    assign p0_preempt = (grant_id != 2'd0) && !in_empty[0];
    assign ptr_upd    = (grant_id != 2'd0);
`else
    assign p0_preempt = 1'b0;
    assign ptr_upd    = 1'b1;
`endif

    // Search order ptr+1, ptr+2, ptr+3, ptr; the 2-bit sum wraps 3 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (!found && !in_empty[ptr + k[1:0]]) begin
                found = 1'b1;
                pick  = ptr + k[1:0];
            end
        end
`ifdef ARB_STRICT_P0_EN
        if (!in_empty[0]) begin
            found = 1'b1;
            pick  = '0;
        end
`endif
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        grant_n     = grant_id;
        burst_cnt_n = burst_cnt;
        gap_n       = gap;
        pop_n       = '0;
        unique case (state)
            IDLE: begin
                if (found && !out_almost_full) begin
                    grant_n     = pick;
                    burst_cnt_n = '0;
                    gap_n       = 1'b0;
                    state_n     = SERVE;
                end
            end
            SERVE: begin
                if (out_almost_full) begin
                    state_n = PAUSE;
                end else begin
                    if (gap) begin
                        // Idle cycle after a pop near empty: in_empty is
                        // not trusted until this pop has reached the source.
                        gap_n = 1'b0;
                    end else if (in_empty[grant_id]) begin
                        state_n = IDLE;
                        if (ptr_upd) ptr_n = grant_id;
                    end else begin
                        pop_n[grant_id] = 1'b1;
                        burst_cnt_n     = burst_cnt + 4'd1;
                        gap_n           = in_almost_empty[grant_id];
                        // Ending on the last pop saves a dead SERVE cycle,
                        // so back-to-back bursts are separated by one IDLE.
                        if (burst_cnt_n == BURST_MAX) begin
                            state_n = IDLE;
                            if (ptr_upd) ptr_n = grant_id;
                        end
                    end
                    if (p0_preempt) begin
                        state_n = IDLE;
                        if (ptr_upd) ptr_n = grant_id;
                    end
                end
            end
            PAUSE: begin
                if (!out_almost_full) state_n = SERVE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sel_data = in_data[DATA_SIZE-1:0];
        for (int unsigned i = 0; i < 4; i++) begin
            if (pend_id == i[1:0]) sel_data = in_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            gap       <= 1'b0;
            pop       <= '0;
            pend      <= 1'b0;
            pend_id   <= '0;
            push      <= 1'b0;
            data_out  <= '0;
            arb_error <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant_id  <= grant_n;
            burst_cnt <= burst_cnt_n;
            gap       <= gap_n;
            pop       <= pop_n;
            // Stage 1: the source presents the popped word this cycle.
            pend      <= |pop;
            pend_id   <= {pop[3] | pop[2], pop[3] | pop[1]};
            // Stage 2: forward it downstream.
            push      <= pend;
            if (pend) data_out <= sel_data;
            if (out_error) arb_error <= 1'b1;
        end
    end

    assign busy = (state != IDLE) || (|pop) || pend || push;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

    localparam int unsigned DS = 10;
    localparam int unsigned BL = 4;
`ifdef ARB_STRICT_P0_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [3:0]      in_empty;
    logic [3:0]      in_almost_empty;
    logic [4*DS-1:0] in_data;
    logic            out_almost_full;
    logic            out_error;
    logic [3:0]      pop;
    logic            push;
    logic [DS-1:0]   data_out;
    logic [1:0]      grant_id;
    logic            busy;
    logic            arb_error;

    fifo_rr_arbiter #(.DATA_SIZE(DS), .BURST_LEN(BL)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_empty        (in_empty),
        .in_almost_empty (in_almost_empty),
        .in_data         (in_data),
        .out_almost_full (out_almost_full),
        .out_error       (out_error),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .grant_id        (grant_id),
        .busy            (busy),
        .arb_error       (arb_error)
    );

    // Source FIFO contents and scoreboard of expected downstream words.
    logic [DS-1:0] srcq [4][$];
    logic [DS-1:0] sb [$];

    int          compared   = 0;
    int          mismatched = 0;
    logic [3:0]  pop_s      = '0;
    logic [3:0]  pop_h1     = '0;
    logic [3:0]  pop_h2     = '0;
    logic        af_prev    = 1'b0;
    bit          mon_off    = 1'b1;
    bit          rand_af    = 1'b0;
    int unsigned pop_cnt    = 0;
    int unsigned push_cnt   = 0;
    int unsigned model_ptr  = 0;
    logic [7:0]  serial     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd_flags();
        for (int i = 0; i < 4; i++) begin
            in_empty[i]        = (srcq[i].size() == 0);
            in_almost_empty[i] = (srcq[i].size() <= 2);
        end
    endtask

    // Advance one cycle; the source FIFOs answer the pops of the cycle just
    // ended, so data and flags change one cycle after a pop.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i]) begin
                chk("src_underflow", 32'(srcq[i].size() != 0), 32'd1);
                if (srcq[i].size() != 0) in_data[i*DS +: DS] = srcq[i].pop_front();
            end
        end
        if (rand_af) out_almost_full = ($urandom_range(0, 99) < 30);
        upd_flags();
    endtask

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            srcq[s].push_back({2'(s), serial});
            serial++;
        end
        upd_flags();
    endtask

    // Reference: whole bursts of min(BURST_LEN, words left), next source
    // searched from pointer+1, pointer set to the source just served.
    task automatic predict();
        int unsigned left [4];
        int unsigned rd [4];
        int          s;
        int unsigned n;
        bit          done;
        for (int i = 0; i < 4; i++) begin
            left[i] = srcq[i].size();
            rd[i]   = 0;
        end
        done = 1'b0;
        while (!done) begin
            s = -1;
            if (STRICT && left[0] > 0) s = 0;
            for (int k = 1; k <= 4; k++) begin
                if (s < 0 && left[(model_ptr + k) % 4] > 0) s = int'((model_ptr + k) % 4);
            end
            if (s < 0) begin
                done = 1'b1;
            end else begin
                n = (left[s] < BL) ? left[s] : BL;
                for (int unsigned k = 0; k < n; k++) sb.push_back(srcq[s][rd[s] + k]);
                rd[s]   += n;
                left[s] -= n;
                if (!(STRICT && s == 0)) model_ptr = s;
            end
        end
    endtask

    function automatic bit any_src();
        return (srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()) != 0;
    endfunction

    task automatic drain(input string name, input int budget);
        int t = 0;
        while ((sb.size() != 0 || busy || any_src()) && t < budget) begin
            tick();
            t++;
        end
        chk({name, "_drained"}, 32'(t < budget), 32'd1);
        chk({name, "_sb_left"}, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every push is checked against the scoreboard head.
    always @(negedge clk) begin
        pop_s = pop;
        if (pop != 0) pop_cnt++;
        if (push) push_cnt++;
        if (mon_off) begin
            pop_h1  = '0;
            pop_h2  = '0;
            af_prev = 1'b0;
        end else begin
            if (push || pop_h2 != 0) chk("push_latency", 32'(push), 32'(pop_h2 != 0));
            if (push) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_extra_push: got push of 0x%0h, expected no push at %0t", data_out, $time);
                end else begin
                    chk("data_out", 32'(data_out), 32'(sb.pop_front()));
                end
            end
            if (af_prev) chk("pop_while_af", 32'(pop), 32'd0);
            if (pop != 0) chk("pop_onehot", 32'($countones(pop)), 32'd1);
            pop_h2  = pop_h1;
            pop_h1  = pop;
            af_prev = out_almost_full;
        end
    end

    initial begin
        int          t;
        int unsigned c0;
        int unsigned p0;
        int unsigned extra;
        bit          seen0;

        reset           = 1'b1;
        out_almost_full = 1'b0;
        out_error       = 1'b0;
        in_data         = '0;
        upd_flags();
        tick();
        tick();

        // Reset with every source holding data.
        for (int s = 0; s < 4; s++) load(s, 3);
        tick();
        chk("reset_pop", 32'(pop), 32'd0);
        chk("reset_push", 32'(push), 32'd0);
        chk("reset_grant", 32'(grant_id), 32'd0);
        chk("reset_arb_error", 32'(arb_error), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        predict();
        reset   = 1'b0;
        mon_off = 1'b0;
        t = 0;
        while (pop == 0 && t < 20) begin
            tick();
            t++;
        end
        chk("first_pop", 32'(pop), STRICT ? 32'd1 : 32'd2);
        chk("first_grant", 32'(grant_id), STRICT ? 32'd0 : 32'd1);
        drain("all_sources", 500);

        // Two sources with 8 words each alternate in bursts of BURST_LEN.
        load(1, 8);
        load(2, 8);
        predict();
        drain("two_sources", 500);

        // Single word: one pop, one push.
        c0 = pop_cnt;
        p0 = push_cnt;
        load(3, 1);
        predict();
        drain("single_word", 200);
        chk("single_word_pops", pop_cnt - c0, 32'd1);
        chk("single_word_pushes", push_cnt - p0, 32'd1);

        // almost_full raised after two pops of a burst.
        c0 = pop_cnt;
        p0 = push_cnt;
        load(1, 8);
        predict();
        t = 0;
        while (pop == 0 && t < 20) begin
            tick();
            t++;
        end
        tick();
        chk("af_second_pop", 32'(pop), 32'd2);
        out_almost_full = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("af_pops_before_pause", pop_cnt - c0, 32'd2);
        chk("af_inflight_pushes", push_cnt - p0, 32'd2);
        out_almost_full = 1'b0;
        drain("af_resume", 500);
        chk("af_total_pops", pop_cnt - c0, 32'd8);

        // Sticky error, then a reset in the middle of a burst.
        out_error = 1'b1;
        tick();
        out_error = 1'b0;
        tick();
        chk("arb_error_set", 32'(arb_error), 32'd1);
        c0 = pop_cnt;
        load(2, 8);
        predict();
        t = 0;
        while (pop_cnt - c0 < 3 && t < 50) begin
            tick();
            t++;
        end
        chk("midburst_reached", 32'(t < 50), 32'd1);
        chk("arb_error_sticky", 32'(arb_error), 32'd1);
        reset   = 1'b1;
        mon_off = 1'b1;
        tick();
        chk("midreset_arb_error", 32'(arb_error), 32'd0);
        chk("midreset_grant", 32'(grant_id), 32'd0);
        for (int s = 0; s < 4; s++) srcq[s].delete();
        sb.delete();
        upd_flags();
        reset     = 1'b0;
        model_ptr = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("after_reset_push", 32'(push), 32'd0);
            chk("after_reset_pop", 32'(pop), 32'd0);
        end
        mon_off = 1'b0;

        // Random loads with random downstream back-pressure.
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 4; s++) load(s, $urandom_range(0, 9));
            predict();
            rand_af = 1'b1;
            drain("random", 3000);
            rand_af         = 1'b0;
            out_almost_full = 1'b0;
        end

`ifdef ARB_STRICT_P0_EN
        // Source 0 becomes non-empty while source 2 is mid-burst.
        mon_off = 1'b1;
        load(2, 8);
        t = 0;
        while (!(pop == 4'b0100) && t < 30) begin
            tick();
            t++;
        end
        chk("p0_src2_started", 32'(t < 30), 32'd1);
        load(0, 3);
        extra = 0;
        seen0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!seen0 && pop[2]) extra++;
            if (grant_id == 2'd0) seen0 = 1'b1;
        end
        chk("p0_extra_src2_pops", 32'(extra <= 1), 32'd1);
        chk("p0_grant", 32'(seen0), 32'd1);
        drain("p0_drain", 500);
        mon_off = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Four-to-one round-robin arbiter that drains four upstream packet FIFOs into one shared downstream FIFO in the PCIe switch datapath. It issues pops to one granted source at a time, in bursts, and pushes the returned words downstream after a fixed latency. Downstream almost_full acts as flow control. A downstream error is latched sticky.

Parameters:
DATA_SIZE, 10, width of one FIFO word
BURST_LEN, 4, maximum pops issued to one source before the grant rotates (1..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_empty  input  4  fifo_empty of sources 3..0
in_almost_empty  input  4  almost_empty of sources 3..0
in_data  input  4*DATA_SIZE  data_out_pop of sources; source i occupies bits [i*DATA_SIZE +: DATA_SIZE]
out_almost_full  input  1  almost_full of downstream FIFO
out_error  input  1  fifo_error of downstream FIFO
pop  output  4  one-hot read strobe to sources, registered
push  output  1  write strobe to downstream FIFO, registered
data_out  output  DATA_SIZE  data_in_push to downstream, registered
grant_id  output  2  currently granted source
busy  output  1  high whenever state is not IDLE or a pop/push is in flight
arb_error  output  1  sticky downstream error

Behaviour:
- Reset values (synchronous reset, takes effect at the next edge):
  - pop=0, push=0, data_out=0, grant_id=0, busy=0, arb_error=0.
  - state=IDLE, round-robin pointer=0, burst counter=0, in-flight pipeline cleared.
- Reset mid-operation: in-flight words are discarded and push is not asserted afterwards.
- Latency: pop[i] high in cycle N -> source presents data in N+1 -> push=1 with data_out=that word in N+2. Exactly one push per pop, in order.
- States:
  - IDLE: search sources starting at pointer+1 mod 4. Choose the first with in_empty=0. If one is found and out_almost_full=0: grant_id<=i, go to SERVE. Otherwise stay.
  - SERVE: each cycle decide pop for grant_id.
    - Issue a pop if in_empty=0 and out_almost_full=0.
    - Back-to-back pops are allowed only while in_almost_empty=0. If in_almost_empty=1, one pop is issued, then a mandatory idle cycle follows before re-sampling in_empty (prevents underflow).
    - Leave to IDLE, pointer<=grant_id, when the burst counter reaches BURST_LEN or the source is empty.
    - Go to PAUSE when out_almost_full=1.
  - PAUSE: no pops. In-flight words still complete their push. Return to SERVE when out_almost_full=0. The burst counter is preserved.
- pop is never asserted when out_almost_full=1 in the same decision cycle.
- The downstream almost_full threshold must leave ≥2 free entries. The arbiter does not check full.
- Pointer wraps 3->0. A single active source keeps winning consecutive bursts, with one IDLE cycle between bursts.
- out_error=1 on any edge sets arb_error=1. It clears only on reset. Arbitration continues.
- busy=1 in SERVE or PAUSE, and while any pop/push is still in the pipeline.

Optional Feature:
ARB_STRICT_P0_EN:
- Defined: source 0 is a strict-priority class.
  - In IDLE, source 0 is granted whenever in_empty[0]=0, regardless of the pointer.
  - In SERVE for another source, in_empty[0]=0 ends the current burst after the current pop, and the grant moves to 0.
  - The pointer is not updated by source-0 bursts.
- Undefined: plain round-robin as above; source 0 gets no preference.

Test Plan:
- Reset with all sources holding data -> pop=0, push=0, grant_id=0, arb_error=0 for the reset cycle. First grant goes to source 1, since the search starts at pointer+1.
- Sources 1 and 2 each hold 8 words, BURST_LEN=4 -> grant order 1,2,1,2. Exactly 4 pops per burst. push follows each pop by 2 cycles. data_out matches source order with no loss or duplicate.
- Source 3 holds 1 word (almost_empty=1) -> single pop, a gap cycle, then in_empty=1 causes exit to IDLE. Exactly one push.
- out_almost_full rises mid-burst after 2 pops -> pops stop in the same cycle. The 2 in-flight pushes still occur. Deassert -> remaining 2 pops of the burst resume.
- out_error pulsed for 1 cycle -> arb_error=1 and stays high through further traffic. Asserting reset -> arb_error=0.
- With ARB_STRICT_P0_EN, source 2 in a burst and source 0 becoming non-empty -> at most one more pop to source 2, then grant_id=0.
